bsr_block_sched: RTL and testbench

- Walks the BSR metadata that the BSR DMA loads into the row_ptr and col_idx BRAMs.
- Emits one descriptor per non-zero 14×14 weight block to the compute front end: block row, block column, and byte base address of that block in the weight BRAM.
- Sits directly downstream of the BSR DMA BRAMs.
- Started by CSR after DMA done. Uses the same start/busy/done/error handshake as the DMA.

---
 rtl/bsr_pkg.sv | 27 ++
 rtl/bsr_block_sched.sv | 193 +++++++++++++++++++
 tb/tb_bsr_block_sched.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsr_pkg.sv
// Shared types and constants for the BSR block scheduler.
package bsr_pkg;

    localparam int BLOCK_DIM       = 14;
    localparam int BEATS_PER_BLOCK = 25;
    localparam int BLOCK_BYTES     = BEATS_PER_BLOCK * 8;
    localparam int DESC_WGT_W      = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_PTR0,
        ST_RD_PTR,
        ST_ROW_CHK,
        ST_RD_COL,
        ST_EMIT,
        ST_DONE
    } bsr_state_e;

    typedef struct packed {
        logic [15:0]           row;
        logic [15:0]           col;
        logic [DESC_WGT_W-1:0] wgt_addr;
        logic                  last_in_row;
        logic                  last;
    } bsr_desc_t;

endpackage

// File: rtl/bsr_block_sched.sv
// Walks BSR row_ptr/col_idx metadata and emits one descriptor per non-zero
// weight block (row, column, weight byte address) to the compute front end.
module bsr_block_sched #(
    parameter int BRAM_ADDR_W     = 10,
    parameter int BEATS_PER_BLOCK = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [31:0]            csr_num_rows,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   row_ptr_re,
    output logic [BRAM_ADDR_W-1:0] row_ptr_raddr,
    input  logic [31:0]            row_ptr_rdata,
    output logic                   col_idx_re,
    output logic [BRAM_ADDR_W-1:0] col_idx_raddr,
    input  logic [15:0]            col_idx_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_row,
    output logic [15:0]            out_col,
    output logic [BRAM_ADDR_W+6:0] out_wgt_addr,
    output logic                   out_last_in_row,
    output logic                   out_last
);
    import bsr_pkg::*;

    localparam int          WGT_W    = BRAM_ADDR_W + 7;
    localparam logic [31:0] STRIDE   = 32'(BEATS_PER_BLOCK * 8);
    localparam logic [31:0] MAX_ROWS = 32'((1 << BRAM_ADDR_W) - 1);

    bsr_state_e       state_q, state_d;
    logic             phase_q, phase_d;
    logic [31:0]      nrows_q, nrows_d;
    logic [31:0]      r_q, r_d;
    logic [31:0]      k_q, k_d;
    logic [31:0]      end_q, end_d;
    logic [WGT_W-1:0] acc_q, acc_d;
    logic             error_q, error_d;
    bsr_desc_t        desc_q, desc_d;

    logic [31:0]      k_inc;
    logic             last_row;

    assign k_inc    = k_q + 32'd1;
    assign last_row = (r_q == nrows_q - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            nrows_q <= '0;
            r_q     <= '0;
            k_q     <= '0;
            end_q   <= '0;
            acc_q   <= '0;
            error_q <= 1'b0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            nrows_q <= nrows_d;
            r_q     <= r_d;
            k_q     <= k_d;
            end_q   <= end_d;
            acc_q   <= acc_d;
            error_q <= error_d;
            desc_q  <= desc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        nrows_d       = nrows_q;
        r_d           = r_q;
        k_d           = k_q;
        end_d         = end_q;
        acc_d         = acc_q;
        error_d       = error_q;
        desc_d        = desc_q;
        row_ptr_re    = 1'b0;
        row_ptr_raddr = '0;
        col_idx_re    = 1'b0;
        col_idx_raddr = '0;
        out_valid     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nrows_d = csr_num_rows;
                    error_d = 1'b0;
                    r_d     = '0;
                    if (csr_num_rows == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (csr_num_rows > MAX_ROWS) begin
                        // row_ptr needs nrows+1 entries; refuse before touching the BRAM
                        state_d = ST_DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_RD_PTR0;
                    end
                end
            end

            ST_RD_PTR0: begin
                row_ptr_re = 1'b1;
                state_d    = ST_RD_PTR;
            end

            ST_RD_PTR: begin
                row_ptr_re    = 1'b1;
                row_ptr_raddr = BRAM_ADDR_W'(r_q + 32'd1);
                // Row 0 is only reached from RD_PTR0, so rdata here holds row_ptr[0]
                if (r_q == 32'd0) begin
                    k_d   = row_ptr_rdata;
                    acc_d = WGT_W'(row_ptr_rdata * STRIDE);
                end
                state_d = ST_ROW_CHK;
            end

            ST_ROW_CHK: begin
                end_d = row_ptr_rdata;
                if (row_ptr_rdata < k_q) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                end else if (row_ptr_rdata == k_q) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = r_q + 32'd1;
                        state_d = ST_RD_PTR;
                    end
                end else begin
                    phase_d = 1'b0;
                    state_d = ST_RD_COL;
                end
            end

            ST_RD_COL: begin
                if (!phase_q) begin
                    col_idx_re    = 1'b1;
                    col_idx_raddr = k_q[BRAM_ADDR_W-1:0];
                    phase_d       = 1'b1;
                end else begin
                    desc_d.row         = r_q[15:0];
                    desc_d.col         = col_idx_rdata;
                    desc_d.wgt_addr    = DESC_WGT_W'(acc_q);
                    desc_d.last_in_row = (k_inc == end_q);
                    desc_d.last        = (k_inc == end_q) && last_row;
                    phase_d            = 1'b0;
                    state_d            = ST_EMIT;
                end
            end

            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    k_d   = k_inc;
                    acc_d = acc_q + WGT_W'(STRIDE);
                    if (k_inc < end_q) begin
                        state_d = ST_RD_COL;
                    end else if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = r_q + 32'd1;
                        state_d = ST_RD_PTR;
                    end
                end
            end

            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done            = (state_q == ST_DONE);
    assign error           = error_q;
    assign out_row         = desc_q.row;
    assign out_col         = desc_q.col;
    assign out_wgt_addr    = WGT_W'(desc_q.wgt_addr);
    assign out_last_in_row = desc_q.last_in_row;
    assign out_last        = desc_q.last;

endmodule

// File: tb/tb_bsr_block_sched.sv
// Self-checking bench for bsr_block_sched: BRAM models, a list-level reference
// model of the BSR walk, directed scenarios and randomized matrices.
module tb_bsr_block_sched;

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic [16:0] addr;
        logic        lir;
        logic        last;
    } d_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] csr_num_rows;
    logic        busy, done, error;
    logic        row_ptr_re, col_idx_re;
    logic [9:0]  row_ptr_raddr, col_idx_raddr;
    logic [31:0] row_ptr_rdata = '0;
    logic [15:0] col_idx_rdata = '0;
    logic        out_valid, out_ready;
    logic [15:0] out_row, out_col;
    logic [16:0] out_wgt_addr;
    logic        out_last_in_row, out_last;

    logic [31:0] rp_mem [1024];
    logic [15:0] ci_mem [1024];

    d_t obs_q[$];
    d_t exp_q[$];
    bit exp_err;
    int rd_cnt, valid_cnt;
    int rdy_mode;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (row_ptr_re) row_ptr_rdata <= rp_mem[row_ptr_raddr];
        if (col_idx_re) col_idx_rdata <= ci_mem[col_idx_raddr];
    end

    bsr_block_sched #(.BRAM_ADDR_W(10), .BEATS_PER_BLOCK(25)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .csr_num_rows(csr_num_rows),
        .busy(busy), .done(done), .error(error),
        .row_ptr_re(row_ptr_re), .row_ptr_raddr(row_ptr_raddr), .row_ptr_rdata(row_ptr_rdata),
        .col_idx_re(col_idx_re), .col_idx_raddr(col_idx_raddr), .col_idx_rdata(col_idx_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_wgt_addr(out_wgt_addr), .out_last_in_row(out_last_in_row), .out_last(out_last)
    );

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observe on the falling edge, then drive just after the rising edge.
    task automatic tick();
        d_t o;
        @(negedge clk);
        if (out_valid && out_ready) begin
            o.row  = out_row;
            o.col  = out_col;
            o.addr = out_wgt_addr;
            o.lir  = out_last_in_row;
            o.last = out_last;
            obs_q.push_back(o);
        end
        if (row_ptr_re || col_idx_re) rd_cnt++;
        if (out_valid) valid_cnt++;
        @(posedge clk);
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rp_mem[i] = '0;
            ci_mem[i] = '0;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        rd_cnt    = 0;
        valid_cnt = 0;
    endtask

    // Reference: every row r owns blocks row_ptr[r] .. row_ptr[r+1]-1.
    task automatic model(input int unsigned nrows);
        d_t e;
        exp_q.delete();
        exp_err = 1'b0;
        if (nrows == 0) return;
        if (nrows > 1023) begin
            exp_err = 1'b1;
            return;
        end
        for (int unsigned r = 0; r < nrows; r++) begin
            if (rp_mem[r+1] < rp_mem[r]) begin
                exp_err = 1'b1;
                return;
            end
            for (int unsigned k = rp_mem[r]; k < rp_mem[r+1]; k++) begin
                e.row  = 16'(r);
                e.col  = ci_mem[k % 1024];
                e.addr = 17'(k * 200);
                e.lir  = (k == rp_mem[r+1] - 1);
                e.last = (k == rp_mem[r+1] - 1) && (r == nrows - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_job(input logic [31:0] n, input int maxc, output bit to, output logic b_done);
        int c = 0;
        csr_num_rows = n;
        start        = 1'b1;
        tick();
        while (!done && c < maxc) begin
            tick();
            c++;
        end
        to     = !done;
        b_done = busy;
        start  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; csr_num_rows = '0; out_ready = 1'b1; rdy_mode = 0;
        repeat (3) tick();
        checks++;
        if ({busy, done, error, row_ptr_re, col_idx_re, out_valid, out_row, out_col, out_wgt_addr,
             out_last_in_row, out_last} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b valid=%b row=%h col=%h addr=%h, want all 0",
                     busy, done, error, out_valid, out_row, out_col, out_wgt_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        d_t want [3];
        int c = 0;
        clear_mem();
        rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 3;
        ci_mem[0] = 1; ci_mem[1] = 4; ci_mem[2] = 0;
        want[0] = {16'd0, 16'd1, 17'd0,   1'b0, 1'b0};
        want[1] = {16'd0, 16'd4, 17'd200, 1'b1, 1'b0};
        want[2] = {16'd1, 16'd0, 17'd400, 1'b1, 1'b1};
        rdy_mode = 0; out_ready = 1'b1;
        clear_obs();
        csr_num_rows = 2;
        start = 1'b1;
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (c !== 6) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, want 6", c);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, want 1", busy);
        end
        while (!done && c < 200) begin
            tick();
            c++;
        end
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic_end: got done=%b err=%b busy=%b, want 1 0 0", done, error, busy);
        end
        start = 1'b0;
        tick();
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d, want 3", obs_q.size());
        end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL basic_desc[%0d]: got %h, want %h", i, obs_q[i], want[i]);
            end
        end
    endtask

    task automatic test_empty_row();
        bit to; logic b;
        clear_mem();
        rp_mem[0] = 0; rp_mem[1] = 1; rp_mem[2] = 1; rp_mem[3] = 2;
        ci_mem[0] = 5; ci_mem[1] = 7;
        rdy_mode = 0;
        clear_obs();
        model(3);
        run_job(3, 200, to, b);
        checks++;
        if (to || error !== 1'b0 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL empty_row_end: got timeout=%b err=%b model_n=%0d, want 0 0 2", to, error, exp_q.size());
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL empty_row_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL empty_row_desc[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        d_t held;
        int c = 0;
        clear_mem();
        rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 3;
        ci_mem[0] = 16'h0011; ci_mem[1] = 16'h0022; ci_mem[2] = 16'h0033;
        model(2);
        rdy_mode = 2; out_ready = 1'b0;
        clear_obs();
        csr_num_rows = 2;
        start = 1'b1;
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
        held = {out_row, out_col, out_wgt_addr, out_last_in_row, out_last};
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || {out_row, out_col, out_wgt_addr, out_last_in_row, out_last} !== held
                || row_ptr_re !== 1'b0 || col_idx_re !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: got valid=%b fields=%h re=%b%b, want 1 %h 00", i, out_valid,
                         {out_row, out_col, out_wgt_addr, out_last_in_row, out_last}, row_ptr_re, col_idx_re, held);
            end
        end
        out_ready = 1'b1;
        c = 0;
        while (!done && c < 200) begin
            tick();
            c++;
        end
        start = 1'b0;
        tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_desc[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_degenerate();
        int c;
        rdy_mode = 0;
        clear_obs();
        csr_num_rows = 0; start = 1'b1; c = 1;
        tick();
        while (!done && c < 10) begin
            tick();
            c++;
        end
        checks++;
        if (c > 2 || done !== 1'b1 || error !== 1'b0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL zero_rows: got cycles=%0d done=%b err=%b valids=%0d, want <=2 1 0 0",
                     c, done, error, valid_cnt);
        end
        start = 1'b0;
        tick();
        clear_obs();
        csr_num_rows = 1024; start = 1'b1; c = 1;
        tick();
        while (!done && c < 10) begin
            tick();
            c++;
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || rd_cnt != 0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL too_many_rows: got done=%b err=%b reads=%0d valids=%0d, want 1 1 0 0",
                     done, error, rd_cnt, valid_cnt);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        bit to; logic b;
        clear_mem();
        rp_mem[0] = 0; rp_mem[1] = 3; rp_mem[2] = 2;
        ci_mem[0] = 2; ci_mem[1] = 3; ci_mem[2] = 9;
        rdy_mode = 0;
        clear_obs();
        model(2);
        run_job(2, 200, to, b);
        checks++;
        if (to || error !== 1'b1 || exp_err !== 1'b1) begin
            errors++;
            $display("FAIL fault_err: got timeout=%b err=%b, want 0 1", to, error);
        end
        checks++;
        if (obs_q.size() != 3 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL fault_count: got %0d, want 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fault_desc[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_control();
        int c = 0;
        bit to; logic b;
        clear_mem();
        rp_mem[0] = 3; rp_mem[1] = 5;
        ci_mem[3] = 16'hABCD; ci_mem[4] = 16'h1234;
        rdy_mode = 2; out_ready = 1'b0;
        clear_obs();
        csr_num_rows = 1; start = 1'b1;
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, row_ptr_re, row_ptr_raddr, col_idx_re, col_idx_raddr, out_valid, out_row,
             out_col, out_wgt_addr, out_last_in_row, out_last} !== '0 || c >= 20) begin
            errors++;
            $display("FAIL reset_in_emit: got valid=%b busy=%b row=%h col=%h addr=%h, want all 0 (wait=%0d)",
                     out_valid, busy, out_row, out_col, out_wgt_addr, c);
        end
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        rdy_mode = 0;
        clear_obs();
        repeat (4) tick();
        checks++;
        if (valid_cnt != 0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_abort: got valids=%0d descs=%0d, want 0 0", valid_cnt, obs_q.size());
        end

        // start held high across DONE
        csr_num_rows = 1; start = 1'b1; c = 0;
        while (!done && c < 100) begin
            tick();
            c++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_hold[%0d]: got done=%b busy=%b, want 1 0", i, done, busy);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_clear: got %b, want 0", done);
        end

        // an erroring job followed by a clean one
        rp_mem[0] = 4; rp_mem[1] = 2;
        run_job(1, 100, to, b);
        checks++;
        if (to || error !== 1'b1) begin
            errors++;
            $display("FAIL restart_fault: got timeout=%b err=%b, want 0 1", to, error);
        end
        rp_mem[0] = 3; rp_mem[1] = 5;
        clear_obs();
        model(1);
        run_job(1, 100, to, b);
        checks++;
        if (to || error !== 1'b0 || b !== 1'b0 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL restart_clean: got timeout=%b err=%b busy=%b descs=%0d, want 0 0 0 %0d",
                     to, error, b, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_desc[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to; logic b;
        int unsigned nrows, fr;
        bit inject;
        for (int it = 0; it < 30; it++) begin
            clear_mem();
            nrows  = $urandom_range(1, 10);
            inject = ($urandom_range(0, 7) == 0);
            fr     = $urandom_range(0, nrows - 1);
            rp_mem[0] = $urandom_range(0, 40);
            for (int unsigned r = 0; r < nrows; r++) begin
                if (inject && r == fr && rp_mem[r] > 0) rp_mem[r+1] = rp_mem[r] - 1;
                else rp_mem[r+1] = rp_mem[r] + $urandom_range(0, 3);
            end
            for (int i = 0; i < 128; i++) ci_mem[i] = 16'($urandom);
            rdy_mode = $urandom_range(0, 1);
            clear_obs();
            model(nrows);
            run_job(nrows, 2000, to, b);
            checks++;
            if (to || error !== exp_err || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand[%0d]_job: got timeout=%b err=%b descs=%0d, want 0 %b %0d",
                         it, to, error, obs_q.size(), exp_err, exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand[%0d]_desc[%0d]: got %h, want %h", it, i, obs_q[i], exp_q[i]);
                end
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_row();
        test_backpressure();
        test_degenerate();
        test_fault();
        test_control();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
